// File: rtl/trace_change_replay.sv
// trace_change_replay
//
// Reader end of the trace value-change stream. It consumes change and time
// records, keeps a shadow image of every traced 1-bit signal, and emits one
// combined frame for each timestamp that had at least one real value change.
//
// Ports:
//   clk, rst_n     clock (posedge) and asynchronous active-low reset
//   in_valid       record present
//   in_ready       record accepted when in_valid && in_ready
//   in_kind        0 = change record, 1 = time record
//   in_data        time record: timestamp
//                  change record: [IDW-1:0] id, [IDW] new value
//   flush          emit the pending frame without a new timestamp
//   frame_valid    frame available
//   frame_ready    frame consumed when frame_valid && frame_ready
//   frame_time     timestamp the frame belongs to
//   frame_bits     full signal image at the end of frame_time
//   frame_changes  real value changes combined into the frame (saturating)
//   err_no_time    sticky: change record before any time record
//   err_bad_id     sticky: change record with id >= NSIG
//   err_time_order sticky: time record not later than the current time
module trace_change_replay #(
  parameter int NSIG = 300,
  parameter int IDW  = $clog2(NSIG),
  parameter int TW   = 32,
  parameter int CW   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_kind,
  input  logic [TW-1:0]   in_data,
  input  logic            flush,
  output logic            frame_valid,
  input  logic            frame_ready,
  output logic [TW-1:0]   frame_time,
  output logic [NSIG-1:0] frame_bits,
  output logic [CW-1:0]   frame_changes,
  output logic            err_no_time,
  output logic            err_bad_id,
  output logic            err_time_order
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_EMIT    = 2'd2;

  localparam logic [IDW:0]  NSIG_W  = NSIG[IDW:0];
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [1:0]      state_q, state_d;
  logic [NSIG-1:0] shadow_q, shadow_d;
  logic [TW-1:0]   cur_time_q, cur_time_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   ftime_q, ftime_d;
  logic [CW-1:0]   fchg_q, fchg_d;
  logic            err_no_time_q, err_no_time_d;
  logic            err_bad_id_q, err_bad_id_d;
  logic            err_order_q, err_order_d;

  logic            accept;
  logic            is_time;
  logic            is_change;
  logic [IDW-1:0]  chg_id;
  logic            chg_val;
  logic            id_ok;

  assign in_ready  = (state_q != S_EMIT);
  assign accept    = in_valid && in_ready;
  assign is_time   = accept && in_kind;
  assign is_change = accept && !in_kind;
  assign chg_id    = in_data[IDW-1:0];
  assign chg_val   = in_data[IDW];
  assign id_ok     = ({1'b0, chg_id} < NSIG_W);

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    cur_time_d    = cur_time_q;
    count_d       = count_q;
    ftime_d       = ftime_q;
    fchg_d        = fchg_q;
    err_no_time_d = err_no_time_q;
    err_bad_id_d  = err_bad_id_q;
    err_order_d   = err_order_q;

    case (state_q)
      S_IDLE: begin
        if (is_time) begin
          cur_time_d = in_data;
          state_d    = S_COLLECT;
        end else if (is_change) begin
          err_no_time_d = 1'b1;
        end
      end

      S_COLLECT: begin
        if (is_change) begin
          if (!id_ok) begin
            err_bad_id_d = 1'b1;
          end else if (shadow_q[chg_id] != chg_val) begin
            shadow_d[chg_id] = chg_val;
            if (count_q != '1) begin
              count_d = count_q + CNT_ONE;
            end
          end
        end

        if (is_time) begin
          // A time record in the same cycle as flush takes precedence.
          if (in_data <= cur_time_q) begin
            err_order_d = 1'b1;
          end else begin
            cur_time_d = in_data;
            if (count_q != '0) begin
              ftime_d = cur_time_q;
              fchg_d  = count_q;
              count_d = '0;
              state_d = S_EMIT;
            end
          end
        end else if (flush && (count_d != '0)) begin
          // count_d already includes a change accepted this same cycle.
          ftime_d = cur_time_q;
          fchg_d  = count_d;
          count_d = '0;
          state_d = S_EMIT;
        end
      end

      S_EMIT: begin
        if (frame_ready) begin
          state_d = S_COLLECT;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      shadow_q      <= '0;
      cur_time_q    <= '0;
      count_q       <= '0;
      ftime_q       <= '0;
      fchg_q        <= '0;
      err_no_time_q <= 1'b0;
      err_bad_id_q  <= 1'b0;
      err_order_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      cur_time_q    <= cur_time_d;
      count_q       <= count_d;
      ftime_q       <= ftime_d;
      fchg_q        <= fchg_d;
      err_no_time_q <= err_no_time_d;
      err_bad_id_q  <= err_bad_id_d;
      err_order_q   <= err_order_d;
    end
  end

  // Input is stalled during EMIT, so the shadow is the frame image.
  assign frame_valid    = (state_q == S_EMIT);
  assign frame_bits     = shadow_q;
  assign frame_time     = ftime_q;
  assign frame_changes  = fchg_q;
  assign err_no_time    = err_no_time_q;
  assign err_bad_id     = err_bad_id_q;
  assign err_time_order = err_order_q;

endmodule

// File: tb/tb_trace_change_replay.sv
module tb_trace_change_replay;

  localparam int NSIG = 300;
  localparam int TW   = 32;
  localparam int CW   = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            in_kind = 1'b0;
  logic [TW-1:0]   in_data = '0;
  logic            flush = 1'b0;
  logic            frame_valid;
  logic            frame_ready = 1'b0;
  logic [TW-1:0]   frame_time;
  logic [NSIG-1:0] frame_bits;
  logic [CW-1:0]   frame_changes;
  logic            err_no_time;
  logic            err_bad_id;
  logic            err_time_order;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NSIG-1:0] exp_bits;

  always #5 clk = ~clk;

  trace_change_replay #(.NSIG(NSIG), .TW(TW), .CW(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_kind        (in_kind),
    .in_data        (in_data),
    .flush          (flush),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .frame_time     (frame_time),
    .frame_bits     (frame_bits),
    .frame_changes  (frame_changes),
    .err_no_time    (err_no_time),
    .err_bad_id     (err_bad_id),
    .err_time_order (err_time_order)
  );

  // All stimulus changes on the negative edge; callers start at a negedge.
  task automatic send(input logic kind, input logic [TW-1:0] data);
    int waited;
    in_valid = 1'b1;
    in_kind  = kind;
    in_data  = data;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%0b required 1 within 20 cycles", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_time(input logic [TW-1:0] t);
    send(1'b1, t);
  endtask

  task automatic send_chg(input int id, input logic val);
    logic [TW-1:0] d;
    d = '0;
    d[8:0] = id[8:0];
    d[9] = val;
    send(1'b0, d);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic consume();
    frame_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    frame_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (frame_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_frame_valid: got %0b required 0", frame_valid);
    end
    n_checks++;
    if (frame_bits !== '0 || frame_changes !== '0 || frame_time !== '0) begin
      n_fail++; $display("FAIL reset_frame_outputs: bits=%0h changes=%0d time=%0d required all 0",
                         frame_bits, frame_changes, frame_time);
    end
    n_checks++;
    if ({err_no_time, err_bad_id, err_time_order} !== 3'b000) begin
      n_fail++; $display("FAIL reset_errors: got %03b required 000",
                         {err_no_time, err_bad_id, err_time_order});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %0b required 1", in_ready);
    end
  endtask

  task automatic test_basic_frame();
    apply_reset();
    send_time(32'd10);
    send_chg(0, 1'b1);
    send_chg(299, 1'b1);
    n_checks++;
    if (frame_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_no_early_frame: frame_valid=%0b required 0", frame_valid);
    end
    send_time(32'd20);
    exp_bits = '0;
    exp_bits[0] = 1'b1;
    exp_bits[299] = 1'b1;
    n_checks++;
    if (frame_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL basic_emit_handshake: valid=%0b ready=%0b required 1/0",
                         frame_valid, in_ready);
    end
    n_checks++;
    if (frame_time !== 32'd10) begin
      n_fail++; $display("FAIL basic_time: got %0d required 10", frame_time);
    end
    n_checks++;
    if (frame_changes !== 16'd2) begin
      n_fail++; $display("FAIL basic_changes: got %0d required 2", frame_changes);
    end
    n_checks++;
    if (frame_bits !== exp_bits) begin
      n_fail++; $display("FAIL basic_bits: got %0h required %0h", frame_bits, exp_bits);
    end
    consume();
    n_checks++;
    if (frame_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_consume: valid=%0b ready=%0b required 0/1",
                         frame_valid, in_ready);
    end
    // Nothing pending: flush must not produce a frame.
    pulse_flush();
    n_checks++;
    if (frame_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_empty_flush: frame_valid=%0b required 0", frame_valid);
    end
  endtask

  task automatic test_same_value();
    apply_reset();
    send_time(32'd5);
    send_chg(3, 1'b1);
    send_chg(3, 1'b0);
    send_chg(3, 1'b0);
    send_time(32'd6);
    n_checks++;
    if (frame_valid !== 1'b1 || frame_time !== 32'd5 || frame_changes !== 16'd2) begin
      n_fail++; $display("FAIL same_value_frame: valid=%0b time=%0d changes=%0d required 1/5/2",
                         frame_valid, frame_time, frame_changes);
    end
    n_checks++;
    if (frame_bits !== '0) begin
      n_fail++; $display("FAIL same_value_bits: got %0h required 0", frame_bits);
    end
    consume();
  endtask

  task automatic test_empty_and_flush();
    apply_reset();
    send_time(32'd1);
    send_time(32'd2);
    send_time(32'd3);
    n_checks++;
    if (frame_valid !== 1'b0) begin
      n_fail++; $display("FAIL empty_times_frame: frame_valid=%0b required 0", frame_valid);
    end
    send_chg(7, 1'b1);
    pulse_flush();
    exp_bits = '0;
    exp_bits[7] = 1'b1;
    n_checks++;
    if (frame_valid !== 1'b1 || frame_time !== 32'd3 || frame_changes !== 16'd1
        || frame_bits !== exp_bits) begin
      n_fail++; $display("FAIL flush_frame: valid=%0b time=%0d changes=%0d bits=%0h required 1/3/1/%0h",
                         frame_valid, frame_time, frame_changes, frame_bits, exp_bits);
    end
    consume();
    // Change and flush on the same edge: the change is included.
    in_valid = 1'b1;
    in_kind  = 1'b0;
    in_data  = 32'h0000_0208;
    flush    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    exp_bits[8] = 1'b1;
    n_checks++;
    if (frame_valid !== 1'b1 || frame_time !== 32'd3 || frame_changes !== 16'd1
        || frame_bits !== exp_bits) begin
      n_fail++; $display("FAIL flush_with_change: valid=%0b time=%0d changes=%0d bits=%0h required 1/3/1/%0h",
                         frame_valid, frame_time, frame_changes, frame_bits, exp_bits);
    end
    consume();
    // Time record and flush together: the time rule wins, frame is for time 3.
    send_chg(9, 1'b1);
    flush = 1'b1;
    send_time(32'd4);
    flush = 1'b0;
    n_checks++;
    if (frame_valid !== 1'b1 || frame_time !== 32'd3 || frame_changes !== 16'd1) begin
      n_fail++; $display("FAIL time_with_flush: valid=%0b time=%0d changes=%0d required 1/3/1",
                         frame_valid, frame_time, frame_changes);
    end
    consume();
  endtask

  task automatic test_errors();
    apply_reset();
    send_chg(4, 1'b1);
    n_checks++;
    if ({err_no_time, err_bad_id, err_time_order} !== 3'b100) begin
      n_fail++; $display("FAIL err_no_time: flags=%03b required 100",
                         {err_no_time, err_bad_id, err_time_order});
    end
    send_time(32'd8);
    send_chg(300, 1'b1);
    n_checks++;
    if ({err_no_time, err_bad_id, err_time_order} !== 3'b110) begin
      n_fail++; $display("FAIL err_bad_id: flags=%03b required 110",
                         {err_no_time, err_bad_id, err_time_order});
    end
    send_time(32'd8);
    n_checks++;
    if ({err_no_time, err_bad_id, err_time_order} !== 3'b111 || frame_valid !== 1'b0) begin
      n_fail++; $display("FAIL err_time_order: flags=%03b valid=%0b required 111/0",
                         {err_no_time, err_bad_id, err_time_order}, frame_valid);
    end
    // The dropped id-4 record must not have touched the shadow.
    send_chg(4, 1'b1);
    send_time(32'd9);
    exp_bits = '0;
    exp_bits[4] = 1'b1;
    n_checks++;
    if (frame_valid !== 1'b1 || frame_time !== 32'd8 || frame_changes !== 16'd1
        || frame_bits !== exp_bits) begin
      n_fail++; $display("FAIL err_shadow_intact: valid=%0b time=%0d changes=%0d bits=%0h required 1/8/1/%0h",
                         frame_valid, frame_time, frame_changes, frame_bits, exp_bits);
    end
    consume();
  endtask

  task automatic test_stall();
    int bad;
    apply_reset();
    send_time(32'd1);
    send_chg(5, 1'b1);
    send_time(32'd2);
    exp_bits = '0;
    exp_bits[5] = 1'b1;
    // Offer a record during the stall; it must wait.
    in_valid = 1'b1;
    in_kind  = 1'b0;
    in_data  = 32'h0000_0206;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (in_ready !== 1'b0 || frame_valid !== 1'b1 || frame_time !== 32'd1
          || frame_changes !== 16'd1 || frame_bits !== exp_bits) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL stall_hold: %0d of 5 cycles unstable, required 0", bad);
    end
    frame_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    frame_ready = 1'b0;
    n_checks++;
    if (frame_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_release: valid=%0b ready=%0b required 0/1",
                         frame_valid, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    send_time(32'd3);
    exp_bits[6] = 1'b1;
    n_checks++;
    if (frame_valid !== 1'b1 || frame_time !== 32'd2 || frame_changes !== 16'd1
        || frame_bits !== exp_bits) begin
      n_fail++; $display("FAIL stall_held_record: valid=%0b time=%0d changes=%0d bits=%0h required 1/2/1/%0h",
                         frame_valid, frame_time, frame_changes, frame_bits, exp_bits);
    end
    consume();
  endtask

  task automatic test_reset_in_emit();
    apply_reset();
    send_time(32'd1);
    send_chg(2, 1'b1);
    send_time(32'd2);
    n_checks++;
    if (frame_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_emit_setup: frame_valid=%0b required 1", frame_valid);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (frame_valid !== 1'b0 || frame_bits !== '0) begin
      n_fail++; $display("FAIL rst_emit_async: valid=%0b bits=%0h required 0/0",
                         frame_valid, frame_bits);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_chg(4, 1'b1);
    n_checks++;
    if (err_no_time !== 1'b1 || frame_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_emit_no_time: err_no_time=%0b valid=%0b required 1/0",
                         err_no_time, frame_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_same_value();
    test_empty_and_flush();
    test_errors();
    test_stall();
    test_reset_in_emit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
